// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted round-robin pop arbiter from VC0/VC1 FIFOs into one downstream FIFO.
// Fixed 2-cycle pop-to-push latency. Optional stats/starvation logic under VC_ARBITER_STATS_EN.
module vc_arbiter #(
  parameter int DATA_WIDTH = 12,
  parameter int VC0_WEIGHT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic                  vc0_empty,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  vc1_empty,
  input  logic                  out_almost_full,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            arb_state
`ifdef VC_ARBITER_STATS_EN
  ,
  output logic [15:0]           cnt_vc0,
  output logic [15:0]           cnt_vc1,
  output logic                  starve_vc1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [3:0] WEIGHT = VC0_WEIGHT[3:0];

  state_e                  state_q, state_d;
  logic [3:0]              credit_q, credit_d;
  logic                    vld_q;
  logic                    sel_q;
  logic                    push_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    gnt0, gnt1;

  // Pops are gated by reset so the FIFOs never lose entries while the arbiter is held.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    credit_d = credit_q;
    state_d  = IDLE;
    if (reset && !out_almost_full) begin
      if (!vc0_empty && ((credit_q < WEIGHT) || vc1_empty)) begin
        gnt0     = 1'b1;
        credit_d = (credit_q == WEIGHT) ? credit_q : credit_q + 4'd1;
      end else if (!vc1_empty) begin
        gnt1     = 1'b1;
        credit_d = 4'd0;
      end
    end
    if (gnt0) begin
      state_d = GNT0;
    end else if (gnt1) begin
      state_d = GNT1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= 4'd0;
      vld_q    <= 1'b0;
      sel_q    <= 1'b0;
      push_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vld_q    <= gnt0 | gnt1;
      sel_q    <= gnt1;
      push_q   <= vld_q;
      if (vld_q) begin
        data_q <= sel_q ? vc1_data : vc0_data;
      end
    end
  end

  assign vc0_pop   = gnt0;
  assign vc1_pop   = gnt1;
  assign push      = push_q;
  assign data_out  = data_q;
  assign arb_state = state_q;

`ifdef VC_ARBITER_STATS_EN
  localparam int         STARVE_LIMIT = 2 * VC0_WEIGHT + 2;
  localparam logic [5:0] STARVE_THR   = STARVE_LIMIT[5:0];

  logic [15:0] cnt0_q, cnt1_q;
  logic [5:0]  starve_q;

  // Counters advance on the same edge that makes the push visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q   <= 16'd0;
      cnt1_q   <= 16'd0;
      starve_q <= 6'd0;
    end else begin
      if (vld_q) begin
        if (sel_q) begin
          cnt1_q <= cnt1_q + 16'd1;
        end else begin
          cnt0_q <= cnt0_q + 16'd1;
        end
      end
      if (vc1_empty || gnt1) begin
        starve_q <= 6'd0;
      end else if (starve_q != 6'h3F) begin
        starve_q <= starve_q + 6'd1;
      end
    end
  end

  assign cnt_vc0    = cnt0_q;
  assign cnt_vc1    = cnt1_q;
  assign starve_vc1 = (starve_q > STARVE_THR);
`endif

endmodule
